steering_ramp: RTL

Avalon-MM slave that accepts a commanded steering angle from the Nios software and slews a 10-bit angle output toward it at a programmable rate, within programmable end-stops. It sits directly upstream of the steering PWM driver: `angle_out` feeds that driver's 10-bit duty/angle input so the servo never receives step changes larger than configured.

---
 rtl/steering_pkg.sv | 39 +++
 rtl/steer_tick_div.sv | 21 ++
 rtl/steering_ramp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/steering_pkg.sv
// Shared constants, state type and helpers for the steering slew block.
// Pure definitions; no latency, no backpressure.
package steering_pkg;
   localparam int ANGLE_W = 10;

   localparam logic [2:0] ADDR_ID      = 3'd0;
   localparam logic [2:0] ADDR_TARGET  = 3'd1;
   localparam logic [2:0] ADDR_STEP    = 3'd2;
   localparam logic [2:0] ADDR_DIVIDER = 3'd3;
   localparam logic [2:0] ADDR_MIN     = 3'd4;
   localparam logic [2:0] ADDR_MAX     = 3'd5;
   localparam logic [2:0] ADDR_STATUS  = 3'd6;
   localparam logic [2:0] ADDR_CTRL    = 3'd7;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_SNAP_BIT = 2;

   typedef enum logic [1:0] {DISABLED, IDLE, RAMP} steer_state_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++)
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   // An inverted window (MIN > MAX) pins the result at MIN.
   function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] tgt,
                                                      input logic [ANGLE_W-1:0] mn,
                                                      input logic [ANGLE_W-1:0] mx);
      if (mn > mx)       return mn;
      else if (tgt < mn) return mn;
      else if (tgt > mx) return mx;
      else               return tgt;
   endfunction
endpackage

// File: rtl/steer_tick_div.sv
// Prescaler: counts 0..i_div and pulses o_tick combinationally at i_div.
// Count held at 0 while disabled or cleared; no backpressure.
module steer_tick_div (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic        i_clr,
   input  logic [15:0] i_div,
   output logic        o_tick
);
   logic [15:0] r_cnt;

   assign o_tick = i_en && (r_cnt >= i_div);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)              r_cnt <= '0;
      else if (i_clr || !i_en) r_cnt <= '0;
      else if (o_tick)        r_cnt <= '0;
      else                    r_cnt <= r_cnt + 16'd1;
   end
endmodule

// File: rtl/steering_ramp.sv
// Avalon-MM slave slewing a 10-bit servo angle toward a clamped target at STEP per tick.
// Writes take effect on the write edge, reads return one clock later; waitrequest is never asserted.
module steering_ramp
   import steering_pkg::*;
#(
   parameter logic [ANGLE_W-1:0] ANGLE_RESET = 10'd512,
   parameter logic [31:0]        ID_WORD     = 32'hEA680013
) (
   input  logic               csi_MCLK_clk,
   input  logic               rsi_MRST_reset,
   input  logic [31:0]        avs_ctrl_writedata,
   output logic [31:0]        avs_ctrl_readdata,
   input  logic [3:0]         avs_ctrl_byteenable,
   input  logic [2:0]         avs_ctrl_address,
   input  logic               avs_ctrl_write,
   input  logic               avs_ctrl_read,
   output logic               avs_ctrl_waitrequest,
   output logic [ANGLE_W-1:0] angle_out,
   output logic               busy,
   output logic               at_target
);
   logic [ANGLE_W-1:0] r_target, r_min, r_max, r_angle;
   logic [7:0]         r_step;
   logic [15:0]        r_div;
   logic               r_enable, r_snap;
   logic [31:0]        r_rdata;
   steer_state_t       r_state;

   logic [ANGLE_W-1:0] w_eff, w_slew, w_angle_nxt;
   steer_state_t       w_state_nxt;
   logic [31:0]        w_reg_view, w_merge;
   logic               w_tick, w_up, w_unused;
   logic [10:0]        w_gap, w_mv, w_sum;

   assign w_eff     = clamp_angle(r_target, r_min, r_max);
   assign angle_out = r_angle;
   assign busy      = (r_state == RAMP);
   assign at_target = (r_angle == w_eff);
   assign avs_ctrl_readdata    = r_rdata;
   assign avs_ctrl_waitrequest = 1'b0;

   steer_tick_div u_div (
      .i_clk  (csi_MCLK_clk),
      .i_rst  (rsi_MRST_reset),
      .i_en   (r_state == RAMP),
      .i_clr  (avs_ctrl_write && (avs_ctrl_address == ADDR_DIVIDER)),
      .i_div  (r_div),
      .o_tick (w_tick)
   );

   always_comb begin
      w_reg_view = '0;
      case (avs_ctrl_address)
         ADDR_ID:      w_reg_view = ID_WORD;
         ADDR_TARGET:  w_reg_view = {22'd0, r_target};
         ADDR_STEP:    w_reg_view = {24'd0, r_step};
         ADDR_DIVIDER: w_reg_view = {16'd0, r_div};
         ADDR_MIN:     w_reg_view = {22'd0, r_min};
         ADDR_MAX:     w_reg_view = {22'd0, r_max};
         ADDR_STATUS:  w_reg_view = {6'd0, r_angle, 14'd0, at_target, busy};
         ADDR_CTRL:    w_reg_view = {31'd0, r_enable};
         default:      w_reg_view = '0;
      endcase
   end

   assign w_merge  = be_merge(w_reg_view, avs_ctrl_writedata, avs_ctrl_byteenable);
   assign w_unused = ^w_merge[31:16];

   // Slew arithmetic at 11 bits; the move is capped at the remaining gap so it cannot overshoot.
   assign w_up   = (w_eff > r_angle);
   assign w_gap  = w_up ? ({1'b0, w_eff} - {1'b0, r_angle}) : ({1'b0, r_angle} - {1'b0, w_eff});
   assign w_mv   = ({3'd0, r_step} >= w_gap) ? w_gap : {3'd0, r_step};
   assign w_sum  = w_up ? ({1'b0, r_angle} + w_mv) : ({1'b0, r_angle} - w_mv);
   assign w_slew = w_sum[10] ? (w_up ? 10'h3FF : 10'h000) : w_sum[9:0];

   always_comb begin
      w_state_nxt = r_state;
      w_angle_nxt = r_angle;
      if (r_snap) begin
         w_angle_nxt = w_eff;
         w_state_nxt = r_enable ? IDLE : DISABLED;
      end else if (!r_enable) begin
         w_state_nxt = DISABLED;
      end else begin
         case (r_state)
            DISABLED: w_state_nxt = IDLE;
            IDLE: begin
               if (r_step == '0)          w_angle_nxt = w_eff;
               else if (r_angle != w_eff) w_state_nxt = RAMP;
            end
            RAMP: begin
               if (r_step == '0) begin
                  w_angle_nxt = w_eff;
                  w_state_nxt = IDLE;
               end else begin
                  if (w_tick) w_angle_nxt = w_slew;
                  if (w_angle_nxt == w_eff) w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_state <= IDLE;
         r_angle <= ANGLE_RESET;
      end else begin
         r_state <= w_state_nxt;
         r_angle <= w_angle_nxt;
      end
   end

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_target <= ANGLE_RESET;
         r_step   <= 8'd1;
         r_div    <= 16'd0;
         r_min    <= '0;
         r_max    <= 10'd1023;
         r_enable <= 1'b1;
         r_snap   <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_snap <= 1'b0;
         if (avs_ctrl_write) begin
            case (avs_ctrl_address)
               ADDR_TARGET:  r_target <= w_merge[ANGLE_W-1:0];
               ADDR_STEP:    r_step   <= w_merge[7:0];
               ADDR_DIVIDER: r_div    <= w_merge[15:0];
               ADDR_MIN:     r_min    <= w_merge[ANGLE_W-1:0];
               ADDR_MAX:     r_max    <= w_merge[ANGLE_W-1:0];
               ADDR_CTRL: begin
                  r_enable <= w_merge[CTRL_EN_BIT];
                  r_snap   <= avs_ctrl_byteenable[0] & avs_ctrl_writedata[CTRL_SNAP_BIT];
               end
               default: ;
            endcase
         end
         if (avs_ctrl_read && !avs_ctrl_write) r_rdata <= w_reg_view;
      end
   end
endmodule
